// File: rtl/var_state_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : var_state_loader_pkg
//  Description : Shared constants, FSM state encoding and slot-position
//                helper for the var-state loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package var_state_loader_pkg;

    localparam int C_NUM_VARS         = 8;
    localparam int C_WIDTH_VAR_STATES = 17;
    localparam int C_WIDTH_ADDR       = 16;
    localparam int C_WIDTH_CNT        = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_LOAD_LAST  = 3'd2,
        ST_STORE_SNAP = 3'd3,
        ST_STORE      = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Slot 0 occupies the most significant field of a packed state bus, so
    // slot k starts (num_vars-1-k) fields above bit 0.
    function automatic int slot_lsb(input int k, input int num_vars, input int width);
        return width * (num_vars - 1 - k);
    endfunction

endpackage : var_state_loader_pkg
`default_nettype wire

// File: rtl/var_state_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : var_state_loader_if
//  Description : Control, RAM and engine-side buses of the var-state loader.
//                slave  = the loader itself, master = controller/RAM/engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface var_state_loader_if
    import var_state_loader_pkg::*;
#(
    parameter int NUM_VARS         = C_NUM_VARS,
    parameter int WIDTH_VAR_STATES = C_WIDTH_VAR_STATES,
    parameter int WIDTH_ADDR       = C_WIDTH_ADDR,
    parameter int WIDTH_CNT        = C_WIDTH_CNT
);

    logic                                 start_load_i;
    logic                                 start_store_i;
    logic [WIDTH_ADDR-1:0]                base_addr_i;
    logic [WIDTH_CNT-1:0]                 num_vars_i;
    logic                                 busy_o;
    logic                                 done_o;
    logic                                 ram_rd_o;
    logic                                 ram_wr_o;
    logic [WIDTH_ADDR-1:0]                ram_addr_o;
    logic [WIDTH_VAR_STATES-1:0]          ram_wdata_o;
    logic [WIDTH_VAR_STATES-1:0]          ram_rdata_i;
    logic [NUM_VARS-1:0]                  wr_states_o;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i;

    modport slave (
        input  start_load_i, start_store_i, base_addr_i, num_vars_i,
        input  ram_rdata_i, vars_states_i,
        output busy_o, done_o, ram_rd_o, ram_wr_o, ram_addr_o, ram_wdata_o,
        output wr_states_o, vars_states_o
    );

    modport master (
        output start_load_i, start_store_i, base_addr_i, num_vars_i,
        output ram_rdata_i, vars_states_i,
        input  busy_o, done_o, ram_rd_o, ram_wr_o, ram_addr_o, ram_wdata_o,
        input  wr_states_o, vars_states_o
    );

endinterface : var_state_loader_if
`default_nettype wire

// File: rtl/var_state_loader.sv
`default_nettype none
// ============================================================================
//  Module      : var_state_loader
//  Description : Moves one bin of variable states between the global
//                var-state RAM and the sat engine's slot array. LOAD streams
//                RAM words into engine slots; STORE snapshots the engine bus
//                and writes it back to RAM one word per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module var_state_loader
    import var_state_loader_pkg::*;
#(
    parameter int NUM_VARS         = C_NUM_VARS,
    parameter int WIDTH_VAR_STATES = C_WIDTH_VAR_STATES,
    parameter int WIDTH_ADDR       = C_WIDTH_ADDR,
    parameter int WIDTH_CNT        = C_WIDTH_CNT
)(
    input  wire logic         clk,
    input  wire logic         rst,
    var_state_loader_if.slave bus
);

    localparam logic [WIDTH_CNT-1:0] C_CNT_MAX  = WIDTH_CNT'(NUM_VARS);
    localparam logic [WIDTH_CNT-1:0] C_CNT_LAST = WIDTH_CNT'(NUM_VARS - 1);
    localparam logic [WIDTH_CNT-1:0] C_CNT_ONE  = WIDTH_CNT'(1);

    state_t                               r_state;
    state_t                               w_next_state;
    logic [WIDTH_CNT-1:0]                 r_cnt;
    logic [WIDTH_CNT-1:0]                 r_num;
    logic [WIDTH_ADDR-1:0]                r_base;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0] r_snap;

    logic [WIDTH_CNT-1:0]                 w_num_clamped;
    logic                                 w_start_any;
    logic                                 w_load_active;
    logic [WIDTH_CNT-1:0]                 w_load_slot;
    logic [WIDTH_VAR_STATES-1:0]          w_load_data;

    // Requested slot count is saturated to the bin size before it is latched.
    assign w_num_clamped = (bus.num_vars_i > C_CNT_MAX) ? C_CNT_MAX : bus.num_vars_i;
    assign w_start_any   = bus.start_load_i | bus.start_store_i;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus RAM strobes, address and status outputs.
    always_comb begin
        w_next_state   = r_state;
        bus.busy_o     = (r_state != ST_IDLE);
        bus.done_o     = 1'b0;
        bus.ram_rd_o   = 1'b0;
        bus.ram_wr_o   = 1'b0;
        bus.ram_addr_o = '0;
        case (r_state)
            ST_IDLE: begin
                // LOAD takes priority when both starts arrive together.
                if (bus.start_load_i) begin
                    w_next_state = ST_LOAD;
                end else if (bus.start_store_i) begin
                    w_next_state = ST_STORE_SNAP;
                end
            end
            ST_LOAD: begin
                // Slots past the valid count are zero-filled without a read.
                if (r_cnt < r_num) begin
                    bus.ram_rd_o   = 1'b1;
                    bus.ram_addr_o = r_base + WIDTH_ADDR'(r_cnt);
                end
                if (r_cnt == C_CNT_LAST) begin
                    w_next_state = ST_LOAD_LAST;
                end
            end
            ST_LOAD_LAST: begin
                w_next_state = ST_DONE;
            end
            ST_STORE_SNAP: begin
                w_next_state = (r_num == '0) ? ST_DONE : ST_STORE;
            end
            ST_STORE: begin
                bus.ram_wr_o   = 1'b1;
                bus.ram_addr_o = r_base + WIDTH_ADDR'(r_cnt);
                if ((r_cnt + C_CNT_ONE) == r_num) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done_o   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Slot counter and operands latched when a start is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_num  <= '0;
            r_base <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_start_any) begin
                        r_base <= bus.base_addr_i;
                        r_num  <= w_num_clamped;
                    end
                end
                ST_LOAD, ST_STORE: begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Engine bus snapshot, taken once so later engine activity cannot leak into RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_snap <= '0;
        end else if (r_state == ST_STORE_SNAP) begin
            r_snap <= bus.vars_states_i;
        end
    end

    // Slot-select mux: routes read data into the slot issued one cycle earlier,
    // and picks the snapshot slot being stored.
    always_comb begin
        w_load_active     = ((r_state == ST_LOAD) && (r_cnt != '0)) || (r_state == ST_LOAD_LAST);
        w_load_slot       = (r_state == ST_LOAD_LAST) ? C_CNT_LAST : (r_cnt - C_CNT_ONE);
        w_load_data       = (w_load_slot < r_num) ? bus.ram_rdata_i : '0;
        bus.wr_states_o   = '0;
        bus.vars_states_o = '0;
        bus.ram_wdata_o   = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            if (w_load_active && (w_load_slot == WIDTH_CNT'(k))) begin
                bus.wr_states_o[NUM_VARS-1-k] = 1'b1;
                bus.vars_states_o[slot_lsb(k, NUM_VARS, WIDTH_VAR_STATES) +: WIDTH_VAR_STATES] = w_load_data;
            end
            if ((r_state == ST_STORE) && (r_cnt == WIDTH_CNT'(k))) begin
                bus.ram_wdata_o = r_snap[slot_lsb(k, NUM_VARS, WIDTH_VAR_STATES) +: WIDTH_VAR_STATES];
            end
        end
    end

endmodule : var_state_loader
`default_nettype wire

// File: tb/tb_var_state_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_var_state_loader
//  Description : Self-checking bench for var_state_loader: cycle-by-cycle
//                expected-output queue plus literal end-of-operation checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_var_state_loader;

    localparam int NV = var_state_loader_pkg::C_NUM_VARS;
    localparam int W  = var_state_loader_pkg::C_WIDTH_VAR_STATES;
    localparam int AW = var_state_loader_pkg::C_WIDTH_ADDR;
    localparam int CW = var_state_loader_pkg::C_WIDTH_CNT;
    localparam logic [W-1:0] JUNK = 17'h15A5A;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic [NV-1:0] wrs;
        logic [W*NV-1:0] vs;
    } obs_t;

    logic clk;
    logic rst;

    var_state_loader_if #(.NUM_VARS(NV), .WIDTH_VAR_STATES(W), .WIDTH_ADDR(AW), .WIDTH_CNT(CW)) bus ();

    var_state_loader #(.NUM_VARS(NV), .WIDTH_VAR_STATES(W), .WIDTH_ADDR(AW), .WIDTH_CNT(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t          exp_q[$];
    int            checks;
    int            errors;
    bit            chk_en;
    int            rd_cnt;
    int            wrs_cnt;
    int            cyc_no;
    logic [W-1:0]  loaded[NV];
    logic [W-1:0]  eng[NV];
    logic [NV-1:0] wrs_log[$];
    logic [AW-1:0] wlog_addr[$];
    logic [W-1:0]  wlog_data[$];
    logic [NV-1:0] wrs_seq[NV];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t obs_now();
        return {bus.busy_o, bus.done_o, bus.ram_rd_o, bus.ram_wr_o, bus.ram_addr_o,
                bus.ram_wdata_o, bus.wr_states_o, bus.vars_states_o};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Packs the engine slot array, slot 0 in the most significant field.
    task automatic set_engine();
        logic [W*NV-1:0] v;
        logic [W*NV-1:0] t;
        v = '0;
        for (int k = 0; k < NV; k++) begin
            t = '0;
            t[W-1:0] = eng[k];
            v = v | (t << (W*(NV-1-k)));
        end
        bus.vars_states_i = v;
    endtask

    // Expected trace of a LOAD: the RAM holds its own address in every word.
    task automatic push_load(input logic [AW-1:0] base, input int num);
        obs_t o;
        int n;
        int s;
        logic [W*NV-1:0] t;
        n = (num > NV) ? NV : num;
        exp_q.push_back('0);
        for (int c = 1; c <= NV + 2; c++) begin
            o = '0;
            o.busy = 1'b1;
            if (c <= NV && (c - 1) < n) begin
                o.rd   = 1'b1;
                o.addr = base + AW'(c - 1);
            end
            if (c >= 2 && c <= NV + 1) begin
                s = c - 2;
                o.wrs = NV'(1) << (NV-1-s);
                if (s < n) begin
                    t = '0;
                    t[W-1:0] = W'(base + AW'(s));
                    o.vs = t << (W*(NV-1-s));
                end
            end
            if (c == NV + 2) o.done = 1'b1;
            exp_q.push_back(o);
        end
    endtask

    // Expected trace of a STORE of the current engine slot values.
    task automatic push_store(input logic [AW-1:0] base, input int num);
        obs_t o;
        int n;
        n = (num > NV) ? NV : num;
        exp_q.push_back('0);
        o = '0;
        o.busy = 1'b1;
        exp_q.push_back(o);
        for (int k = 0; k < n; k++) begin
            o = '0;
            o.busy  = 1'b1;
            o.wr    = 1'b1;
            o.addr  = base + AW'(k);
            o.wdata = eng[k];
            exp_q.push_back(o);
        end
        o = '0;
        o.busy = 1'b1;
        o.done = 1'b1;
        exp_q.push_back(o);
    endtask

    task automatic start_op(input bit ld, input bit st, input logic [AW-1:0] base, input logic [CW-1:0] num);
        bus.start_load_i  = ld;
        bus.start_store_i = st;
        bus.base_addr_i   = base;
        bus.num_vars_i    = num;
        cyc();
        bus.start_load_i  = 1'b0;
        bus.start_store_i = 1'b0;
        bus.base_addr_i   = 16'hDEAD;
        bus.num_vars_i    = 4'd5;
    endtask

    // Waits for done_o counting cycles after accept; optionally pulses a
    // stray store start or scrambles the engine bus at a given cycle.
    task automatic wait_done(input int inject_at, input int junk_at, output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            bus.start_store_i = (n == inject_at);
            if (n == junk_at) begin
                for (int k = 0; k < NV; k++) eng[k] = 17'h1FFFF;
                set_engine();
            end
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                lat = n;
                break;
            end
            cyc();
        end
        bus.start_store_i = 1'b0;
        cyc();
    endtask

    // Per-cycle compare against the expected queue, strobe monitor and RAM model.
    task automatic sim_loop();
        obs_t act;
        obs_t exp;
        logic p_rd;
        logic p_wr;
        logic [AW-1:0] p_addr;
        logic [W-1:0] p_wdata;
        forever begin
            @(negedge clk);
            cyc_no++;
            act     = obs_now();
            p_rd    = bus.ram_rd_o;
            p_wr    = bus.ram_wr_o;
            p_addr  = bus.ram_addr_o;
            p_wdata = bus.ram_wdata_o;
            if (bus.ram_rd_o) rd_cnt++;
            if (bus.wr_states_o != '0) begin
                wrs_cnt++;
                wrs_log.push_back(bus.wr_states_o);
                for (int k = 0; k < NV; k++) begin
                    if (((bus.wr_states_o >> (NV-1-k)) & NV'(1)) != '0)
                        loaded[k] = W'(bus.vars_states_o >> (W*(NV-1-k)));
                end
            end
            if (chk_en) begin
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                else exp = '0;
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL cycle %0d: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h wrs=%h vs=%h expected busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h wrs=%h vs=%h",
                             cyc_no, act.busy, act.done, act.rd, act.wr, act.addr, act.wdata, act.wrs, act.vs,
                             exp.busy, exp.done, exp.rd, exp.wr, exp.addr, exp.wdata, exp.wrs, exp.vs);
                end
            end
            @(posedge clk);
            bus.ram_rdata_i = p_rd ? W'(p_addr) : JUNK;
            if (p_wr) begin
                wlog_addr.push_back(p_addr);
                wlog_data.push_back(p_wdata);
            end
        end
    endtask

    initial begin
        int lat;
        int r0;
        int w0;
        int l0;
        int a0;
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        rd_cnt = 0;
        wrs_cnt = 0;
        cyc_no = 0;
        wrs_seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        for (int k = 0; k < NV; k++) begin
            eng[k]    = '0;
            loaded[k] = '0;
        end
        rst               = 1'b0;
        bus.start_load_i  = 1'b0;
        bus.start_store_i = 1'b0;
        bus.base_addr_i   = '0;
        bus.num_vars_i    = '0;
        bus.ram_rdata_i   = JUNK;
        bus.vars_states_i = '0;
        fork
            sim_loop();
        join_none

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", longint'(obs_now() != '0), 0);
        check("reset_busy", longint'(bus.busy_o), 0);
        rst    = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Full LOAD of 8 slots.
        r0 = rd_cnt; w0 = wrs_cnt; l0 = wrs_log.size();
        push_load(16'h0100, 8);
        start_op(1'b1, 1'b0, 16'h0100, 4'd8);
        wait_done(0, 0, lat);
        check("load8_latency", longint'(lat), 10);
        check("load8_reads", longint'(rd_cnt - r0), 8);
        check("load8_slot_writes", longint'(wrs_cnt - w0), 8);
        for (int k = 0; k < NV; k++) begin
            check("load8_wrs_seq", longint'(wrs_log[l0+k]), longint'(wrs_seq[k]));
            check("load8_slot", longint'(loaded[k]), longint'(32'h100 + k));
        end

        // Partial LOAD: slots 3..7 zero-filled, still 8 slot writes.
        r0 = rd_cnt; w0 = wrs_cnt;
        push_load(16'h0100, 3);
        start_op(1'b1, 1'b0, 16'h0100, 4'd3);
        wait_done(0, 0, lat);
        check("load3_latency", longint'(lat), 10);
        check("load3_reads", longint'(rd_cnt - r0), 3);
        check("load3_slot_writes", longint'(wrs_cnt - w0), 8);
        check("load3_slot2", longint'(loaded[2]), 64'h102);
        check("load3_slot3", longint'(loaded[3]), 0);
        check("load3_slot7", longint'(loaded[7]), 0);

        // STORE with address wrap; engine bus scrambled after the snapshot.
        eng = '{17'h1A, 17'h1B, 17'h1C, 17'h1D, 17'h1E, 17'h1F, 17'h20, 17'h21};
        set_engine();
        a0 = wlog_addr.size();
        push_store(16'hFFFE, 4);
        start_op(1'b0, 1'b1, 16'hFFFE, 4'd4);
        wait_done(0, 2, lat);
        check("store4_latency", longint'(lat), 6);
        check("store4_writes", longint'(wlog_addr.size() - a0), 4);
        if (wlog_addr.size() >= a0 + 4) begin
            check("store4_addr0", longint'(wlog_addr[a0+0]), 64'hFFFE);
            check("store4_addr1", longint'(wlog_addr[a0+1]), 64'hFFFF);
            check("store4_addr2", longint'(wlog_addr[a0+2]), 64'h0000);
            check("store4_addr3", longint'(wlog_addr[a0+3]), 64'h0001);
            check("store4_data0", longint'(wlog_data[a0+0]), 64'h1A);
            check("store4_data1", longint'(wlog_data[a0+1]), 64'h1B);
            check("store4_data2", longint'(wlog_data[a0+2]), 64'h1C);
            check("store4_data3", longint'(wlog_data[a0+3]), 64'h1D);
        end

        // Both starts together: LOAD wins, no RAM writes.
        r0 = rd_cnt; a0 = wlog_addr.size();
        push_load(16'h0200, 8);
        start_op(1'b1, 1'b1, 16'h0200, 4'd8);
        wait_done(0, 0, lat);
        check("both_latency", longint'(lat), 10);
        check("both_reads", longint'(rd_cnt - r0), 8);
        check("both_no_writes", longint'(wlog_addr.size() - a0), 0);

        // Stray store start during LOAD is ignored.
        a0 = wlog_addr.size();
        push_load(16'h0300, 8);
        start_op(1'b1, 1'b0, 16'h0300, 4'd8);
        wait_done(3, 0, lat);
        check("midstore_latency", longint'(lat), 10);
        check("midstore_no_writes", longint'(wlog_addr.size() - a0), 0);
        check("midstore_idle_after", longint'(bus.busy_o), 0);

        // Oversized counts clamp to the bin size.
        eng = '{17'h10, 17'h11, 17'h12, 17'h13, 17'h14, 17'h15, 17'h16, 17'h17};
        set_engine();
        a0 = wlog_addr.size();
        push_store(16'h4000, 15);
        start_op(1'b0, 1'b1, 16'h4000, 4'd15);
        wait_done(0, 0, lat);
        check("store15_latency", longint'(lat), 10);
        check("store15_writes", longint'(wlog_addr.size() - a0), 8);
        if (wlog_addr.size() >= a0 + 8) begin
            check("store15_last_addr", longint'(wlog_addr[a0+7]), 64'h4007);
            check("store15_last_data", longint'(wlog_data[a0+7]), 64'h17);
        end
        r0 = rd_cnt;
        push_load(16'h0500, 9);
        start_op(1'b1, 1'b0, 16'h0500, 4'd9);
        wait_done(0, 0, lat);
        check("load9_reads", longint'(rd_cnt - r0), 8);

        // Empty STORE goes straight to DONE.
        a0 = wlog_addr.size();
        push_store(16'h0600, 0);
        start_op(1'b0, 1'b1, 16'h0600, 4'd0);
        wait_done(0, 0, lat);
        check("store0_latency", longint'(lat), 2);
        check("store0_no_writes", longint'(wlog_addr.size() - a0), 0);

        // Reset while LOAD is at slot 4, then a clean LOAD.
        r0 = rd_cnt; w0 = wrs_cnt;
        push_load(16'h0700, 8);
        start_op(1'b1, 1'b0, 16'h0700, 4'd8);
        repeat (4) cyc();
        rst = 1'b0;
        cyc();
        exp_q.delete();
        rst = 1'b1;
        repeat (4) cyc();
        check("abort_reads", longint'(rd_cnt - r0), 5);
        check("abort_slot_writes", longint'(wrs_cnt - w0), 4);
        push_load(16'h0800, 8);
        start_op(1'b1, 1'b0, 16'h0800, 4'd8);
        wait_done(0, 0, lat);
        check("after_abort_latency", longint'(lat), 10);
        check("after_abort_slot0", longint'(loaded[0]), 64'h800);
        check("after_abort_slot7", longint'(loaded[7]), 64'h807);

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_var_state_loader
`default_nettype wire
